// File: rtl/gray_dec_chk.sv
// Gray-code decoder with sequence checker: decodes each accepted sample,
// tracks whether successive samples step by +1 and counts violations once locked.
//
// state  | meaning
// IDLE   | no reference yet; next accepted sample only loads ref
// ACQ    | reference held; waiting for one expected step to lock
// LOCKED | tracking; any unexpected step is a sequence violation
module gray_dec_chk #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out,
  output logic             valid_out,
  output logic             seq_err,
  output logic             locked,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACQ    = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] decoded;
  logic [WIDTH-1:0] ref_next;
  logic             expected;
  logic             cnt_full;

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    decoded = '0;
    for (int i = 0; i < WIDTH; i++) begin
      decoded[i] = ^(gray_in >> i);
    end
  end

  assign ref_next = ref_q + WIDTH'(1);
  assign expected = (decoded == ref_next);
  assign cnt_full = (err_count == {CNT_W{1'b1}});
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ref_q     <= '0;
      bin_out   <= '0;
      valid_out <= 1'b0;
      seq_err   <= 1'b0;
      err_count <= '0;
    end else begin
      valid_out <= 1'b0;
      seq_err   <= 1'b0;
      if (enable) begin
        bin_out   <= decoded;
        ref_q     <= decoded;
        valid_out <= 1'b1;
        case (state)
          IDLE: state <= ACQ;
          ACQ: begin
            if (expected) state <= LOCKED;
          end
          LOCKED: begin
            if (!expected) begin
              seq_err <= 1'b1;
              state   <= ACQ;
              if (!cnt_full) err_count <= err_count + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
